// File: rtl/matmul_ktile_sequencer.sv
// K-tile sequencer for the matrix multiply-accumulate unit.
// Streams A/B tiles of one job into a single MAC, feeding each returned D back
// as the C operand of the next tile, and emits the final D on a result channel.
// A small protocol checker sits alongside the sequencer and is bound in below.

module matmul_ktile_sequencer_chk (
    input logic clk_i,
    input logic rst_i,
    input logic mac_valid_o,
    input logic mac_ready_i,
    input logic mac_valid_i,
    input logic mac_ready_o,
    input logic res_valid_o,
    input logic res_ready_i
);

    // A MAC response may only arrive while the sequencer can accept it (IDLE or WAIT).
    a_rsp_when_ready: assert property (@(posedge clk_i) disable iff (rst_i)
        mac_valid_i |-> mac_ready_o);

    // A raised MAC request is held until it is taken.
    a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (mac_valid_o && !mac_ready_i) |=> mac_valid_o);

    // A raised result is held until it is taken.
    a_res_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (res_valid_o && !res_ready_i) |=> res_valid_o);

endmodule

module matmul_ktile_sequencer #(
    parameter int M    = 2,
    parameter int N    = 2,
    parameter int K    = 2,
    parameter int P    = 8,
    parameter int KT_W = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [KT_W-1:0]                 num_ktiles_i,
    input  logic [M-1:0][N-1:0][4*P-1:0]    bias_i,
    input  logic                            tile_valid_i,
    output logic                            tile_ready_o,
    input  logic [M-1:0][K-1:0][P-1:0]      tile_A_i,
    input  logic [K-1:0][N-1:0][P-1:0]      tile_B_i,
    output logic                            mac_valid_o,
    input  logic                            mac_ready_i,
    output logic [M-1:0][K-1:0][P-1:0]      mac_A_o,
    output logic [K-1:0][N-1:0][P-1:0]      mac_B_o,
    output logic [M-1:0][N-1:0][4*P-1:0]    mac_C_o,
    input  logic                            mac_valid_i,
    output logic                            mac_ready_o,
    input  logic [M-1:0][N-1:0][4*P-1:0]    mac_D_i,
    output logic                            res_valid_o,
    input  logic                            res_ready_i,
    output logic [M-1:0][N-1:0][4*P-1:0]    res_D_o,
    output logic                            busy_o,
    output logic [KT_W-1:0]                 tiles_left_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FETCH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [KT_W-1:0] KT_ZERO = {KT_W{1'b0}};
    localparam logic [KT_W-1:0] KT_ONE  = {{(KT_W-1){1'b0}}, 1'b1};

    state_t                         state_r;
    state_t                         state_s;
    logic [M-1:0][N-1:0][4*P-1:0]   acc_r;
    logic [KT_W-1:0]                tiles_left_r;
    logic [KT_W-1:0]                first_left_s;
    logic                           tile_hs_s;
    logic                           req_hs_s;
    logic                           rsp_hs_s;
    logic                           res_hs_s;

    assign tile_hs_s = tile_valid_i & tile_ready_o;
    assign req_hs_s  = mac_valid_o  & mac_ready_i;
    assign rsp_hs_s  = mac_valid_i  & mac_ready_o;
    assign res_hs_s  = res_valid_o  & res_ready_i;

    // A tile count of zero is run as a single tile.
    assign first_left_s = (num_ktiles_i == KT_ZERO) ? KT_ZERO : (num_ktiles_i - KT_ONE);

    assign res_D_o      = acc_r;
    assign tiles_left_o = tiles_left_r;

    // Next-state decode; a response seen in IDLE is a leftover from an aborted job and is dropped.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (tile_hs_s) state_s = S_ISSUE;
                else           state_s = S_IDLE;
            end
            S_ISSUE: begin
                if (req_hs_s) state_s = S_WAIT;
                else          state_s = S_ISSUE;
            end
            S_WAIT: begin
                if (rsp_hs_s) begin
                    if (tiles_left_r == KT_ZERO) state_s = S_DONE;
                    else                         state_s = S_FETCH;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_FETCH: begin
                if (tile_hs_s) state_s = S_ISSUE;
                else           state_s = S_FETCH;
            end
            S_DONE: begin
                if (res_hs_s) state_s = S_IDLE;
                else          state_s = S_DONE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_r <= S_IDLE;
        else       state_r <= state_s;
    end

    // Handshake/status outputs registered from the next state so they track state_r exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tile_ready_o <= 1'b1;
            mac_valid_o  <= 1'b0;
            mac_ready_o  <= 1'b1;
            res_valid_o  <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            tile_ready_o <= (state_s == S_IDLE) || (state_s == S_FETCH);
            mac_valid_o  <= (state_s == S_ISSUE);
            mac_ready_o  <= (state_s == S_IDLE) || (state_s == S_WAIT);
            res_valid_o  <= (state_s == S_DONE);
            busy_o       <= (state_s != S_IDLE);
        end
    end

    // Operand, accumulator and tile-counter registers; C comes from bias on the first tile, else from the last D.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mac_A_o      <= '0;
            mac_B_o      <= '0;
            mac_C_o      <= '0;
            acc_r        <= '0;
            tiles_left_r <= KT_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (tile_hs_s) begin
                        mac_A_o      <= tile_A_i;
                        mac_B_o      <= tile_B_i;
                        mac_C_o      <= bias_i;
                        tiles_left_r <= first_left_s;
                    end
                end
                S_WAIT: begin
                    if (rsp_hs_s) acc_r <= mac_D_i;
                end
                S_FETCH: begin
                    if (tile_hs_s) begin
                        mac_A_o      <= tile_A_i;
                        mac_B_o      <= tile_B_i;
                        mac_C_o      <= acc_r;
                        tiles_left_r <= tiles_left_r - KT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    matmul_ktile_sequencer_chk u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mac_valid_o (mac_valid_o),
        .mac_ready_i (mac_ready_i),
        .mac_valid_i (mac_valid_i),
        .mac_ready_o (mac_ready_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i)
    );

endmodule
